// File: rtl/ram_param.sv
// ram_param: single-port RAM with registered read and optional post-reset zero-fill (RAM_PARAM_CLEAR_EN)
module ram_param #(
  parameter int WIDTH = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] sel,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);
  logic [WIDTH-1:0] mem [2**ADDR_W];
  logic we;
  logic [ADDR_W-1:0] wa;
  logic [WIDTH-1:0] wd;
`ifdef RAM_PARAM_CLEAR_EN
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] clr_addr;
  always_ff @(posedge clk) begin
    state <= reset ? CLEAR : state_n;
    busy <= reset | (state_n == CLEAR);
    clr_addr <= reset ? '0 : (state == CLEAR ? clr_addr + ADDR_W'(1) : clr_addr);
  end
  always_comb begin
    state_n = (state == CLEAR && &clr_addr) ? IDLE : state;
    we = busy | load;
    wa = busy ? clr_addr : sel;
    wd = busy ? '0 : in;
  end
`else
  assign busy = 1'b0;
  always_comb begin
    we = load;
    wa = sel;
    wd = in;
  end
`endif
  always_ff @(posedge clk)
    if (!reset && we) mem[wa] <= wd;
  always_ff @(posedge clk)
    out <= (reset | busy) ? '0 : mem[sel];
endmodule

// File: tb/tb_ram_param.sv
// tb_ram_param: directed scoreboard bench for ram_param (16x16 and default 4096x16), both RAM_PARAM_CLEAR_EN builds
module tb_ram_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] in = '0;
  logic load = 1'b0;
  logic [3:0] sel = '0;
  logic [15:0] out;
  logic busy;
  logic [15:0] b_in = '0;
  logic b_load = 1'b0;
  logic [11:0] b_sel = '0;
  logic [15:0] b_out;
  logic b_busy;
  int tests = 0;
  int fails = 0;
  logic [15:0] expq[$];
  string tagq[$];
  always #5 clk = ~clk;
  ram_param #(.WIDTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .sel(sel), .out(out), .busy(busy)
  );
  ram_param u_big (
    .clk(clk), .reset(reset), .in(b_in), .load(b_load), .sel(b_sel), .out(b_out), .busy(b_busy)
  );
  task automatic check(input string t, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cyc(input logic l, input logic [15:0] d, input logic [3:0] a, input logic chk, input logic [15:0] e, input string t);
    load = l;
    in = d;
    sel = a;
    if (chk) begin
      expq.push_back(e);
      tagq.push_back(t);
    end
    tick();
    load = 1'b0;
    if (chk) check(tagq.pop_front(), out, expq.pop_front());
  endtask
  task automatic busy_count(input string t);
    int n = 0;
    while (busy && n < 40) begin
      check({t, "_out0"}, out, 16'h0000);
      n++;
      tick();
    end
    load = 1'b0;
    check({t, "_cycles"}, n, 16);
  endtask
  initial begin
    int n;
    reset = 1'b1;
    tick();
    check("reset_out", out, 16'h0000);
`ifdef RAM_PARAM_CLEAR_EN
    check("reset_busy", busy, 1'b1);
    reset = 1'b0;
    load = 1'b1;
    in = 16'hFFFF;
    sel = 4'd2;
    busy_count("clear1");
    check("idle_busy", busy, 1'b0);
    for (int a = 0; a < 16; a++) cyc(1'b0, 16'h0, a[3:0], 1'b1, 16'h0000, $sformatf("zero_a%0d", a));
`else
    check("reset_busy", busy, 1'b0);
    reset = 1'b0;
    cyc(1'b1, 16'h00A5, 4'd15, 1'b0, 16'h0, "");
    cyc(1'b0, 16'h0, 4'd15, 1'b1, 16'h00A5, "first_edge_write");
    reset = 1'b1;
    cyc(1'b1, 16'h1111, 4'd15, 1'b0, 16'h0, "");
    check("reset_wins_out", out, 16'h0000);
    reset = 1'b0;
    cyc(1'b0, 16'h0, 4'd15, 1'b1, 16'h00A5, "reset_wins_mem");
`endif
    cyc(1'b1, 16'hBEEF, 4'd5, 1'b0, 16'h0, "");
    cyc(1'b0, 16'h0, 4'd5, 1'b1, 16'hBEEF, "read_beef");
`ifdef RAM_PARAM_CLEAR_EN
    cyc(1'b0, 16'h0, 4'd6, 1'b1, 16'h0000, "read_6_zero");
`endif
    cyc(1'b1, 16'h1234, 4'd3, 1'b0, 16'h0, "");
    cyc(1'b1, 16'h5678, 4'd3, 1'b1, 16'h1234, "rdw_old");
    cyc(1'b0, 16'h0, 4'd3, 1'b1, 16'h5678, "rdw_new");
    check("idle_busy2", busy, 1'b0);
`ifdef RAM_PARAM_CLEAR_EN
    for (int a = 0; a < 16; a++) cyc(1'b1, 16'h0100 + 16'(a), a[3:0], 1'b0, 16'h0, "");
    cyc(1'b0, 16'h0, 4'd9, 1'b1, 16'h0109, "fill_9");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check("mid_clear_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    busy_count("clear2");
    for (int a = 0; a < 16; a++) cyc(1'b0, 16'h0, a[3:0], 1'b1, 16'h0000, $sformatf("reclear_a%0d", a));
`endif
    n = 0;
    while (b_busy && n < 5000) begin
      n++;
      tick();
    end
    check("big_busy_done", b_busy, 1'b0);
    b_load = 1'b1;
    b_in = 16'hC0DE;
    b_sel = 12'hFFF;
    tick();
    b_in = 16'h1111;
    b_sel = 12'h000;
    tick();
    b_load = 1'b0;
    b_sel = 12'hFFF;
    tick();
    check("big_fff", b_out, 16'hC0DE);
    b_sel = 12'h000;
    tick();
    check("big_000", b_out, 16'h1111);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
